fb_scanout: RTL and testbench

Scan-out stage downstream of the block renderer. Reads the 2-bit draw buffer one pixel at a time, maps each value through a fixed palette, and drives 640x480 VGA timing. Owns double-buffer selection: the renderer draws into the back buffer, and scan-out swaps buffers at the start of vertical blanking when a swap has been requested.

---
 rtl/fb_scanout.sv | 182 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: VGA scan-out stage. Walks the raster, reads the 2-bit draw
// buffer one pixel ahead, maps it through a fixed palette and drives
// sync/DE/RGB. Owns front/back buffer selection and swaps at vblank.
// Ports: clk, rst (sync, active-high), pix_stb (pixel enable),
//   swap_req/swap_ack (swap handshake), front_sel (scanned buffer),
//   draw_addr_read/draw_data_out (buffer read, 1 clk latency),
//   vga_r/g/b, vga_hs, vga_vs (active-low), vga_de, frame_start.
// Option: define SCANOUT_BORDER_EN to force a white 1-pixel border.
module fb_scanout #(
  parameter int DRAW_WIDTH  = 640,
  parameter int DRAW_HEIGHT = 480,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int DRAW_DATAW  = 2,
  parameter int DRAW_ADDRW  = $clog2(DRAW_WIDTH * DRAW_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_stb,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  front_sel,
  output logic [DRAW_ADDRW-1:0] draw_addr_read,
  input  logic [DRAW_DATAW-1:0] draw_data_out,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic                  frame_start
);

  localparam int H_TOTAL = DRAW_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = DRAW_HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(DRAW_WIDTH);
  localparam logic [HW-1:0] H_ALAST = HW'(DRAW_WIDTH - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(DRAW_WIDTH + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(DRAW_WIDTH + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(DRAW_HEIGHT);
  localparam logic [VW-1:0] V_ALAST = VW'(DRAW_HEIGHT - 1);
  localparam logic [VW-1:0] VS_BEG  = VW'(DRAW_HEIGHT + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(DRAW_HEIGHT + V_FP + V_SYNC - 1);
  localparam logic [DRAW_ADDRW-1:0] LINE_STEP = DRAW_ADDRW'(DRAW_WIDTH);

`ifdef SCANOUT_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  typedef enum logic {IDLE, PENDING} state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         sx_q, sx_d;
  logic [VW-1:0]         sy_q, sy_d;
  logic [DRAW_ADDRW-1:0] base_q, base_d;
  logic [DRAW_ADDRW-1:0] addr_q, addr_d;
  logic [11:0]           rgb_q, rgb_d;
  logic                  de_q, hs_q, vs_q;
  logic                  ack_q, fsel_q, fs_q;

  logic h_wrap, v_wrap, swap_pt, swap_fire;
  logic de_cur, hs_cur, vs_cur, border;

  // Raster advance; base tracks sy*DRAW_WIDTH only across active lines.
  always_comb begin
    h_wrap = (sx_q == H_LAST);
    v_wrap = (sy_q == V_LAST);
    sx_d   = h_wrap ? '0 : sx_q + 1'b1;
    sy_d   = sy_q;
    base_d = base_q;
    if (h_wrap) begin
      if (v_wrap) begin
        sy_d   = '0;
        base_d = '0;
      end else begin
        sy_d = sy_q + 1'b1;
        if (sy_q < V_ALAST)
          base_d = base_q + LINE_STEP;
      end
    end
    if (sx_d < H_ACT && sy_d < V_ACT)
      addr_d = base_d + DRAW_ADDRW'(sx_d);
    else
      addr_d = addr_q;
  end

  // Output values for the position held before the advance.
  always_comb begin
    de_cur = (sx_q < H_ACT) && (sy_q < V_ACT);
    hs_cur = !((sx_q >= HS_BEG) && (sx_q <= HS_END));
    vs_cur = !((sy_q >= VS_BEG) && (sy_q <= VS_END));
    border = BORDER_EN &&
             (sx_q == '0 || sx_q == H_ALAST ||
              sy_q == '0 || sy_q == V_ALAST);
    rgb_d  = 12'h000;
    if (de_cur) begin
      unique case (draw_data_out)
        2'd0:    rgb_d = 12'h000;
        2'd1:    rgb_d = 12'h00F;
        2'd2:    rgb_d = 12'h0F0;
        default: rgb_d = 12'hFFF;
      endcase
      if (border)
        rgb_d = 12'hFFF;
    end
  end

  // Swap FSM: swap point is the strobe entering the first blanking line.
  always_comb begin
    swap_pt   = pix_stb && h_wrap && (sy_q == V_ALAST);
    state_d   = state_q;
    swap_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (swap_req && swap_pt)
          swap_fire = 1'b1;
        else if (swap_req)
          state_d = PENDING;
      end
      PENDING: begin
        if (swap_pt) begin
          swap_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ack_q   <= 1'b0;
      fsel_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= swap_fire;
      fsel_q  <= fsel_q ^ swap_fire;
      fs_q    <= pix_stb && h_wrap && v_wrap;
      if (pix_stb) begin
        sx_q   <= sx_d;
        sy_q   <= sy_d;
        base_q <= base_d;
        addr_q <= addr_d;
        rgb_q  <= rgb_d;
        de_q   <= de_cur;
        hs_q   <= hs_cur;
        vs_q   <= vs_cur;
      end
    end
  end

  assign draw_addr_read = addr_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_de      = de_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign swap_ack    = ack_q;
  assign front_sel   = fsel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench for fb_scanout on a reduced raster.
// Expected pixels are queued per strobe and popped when outputs update.
module tb_fb_scanout;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 2;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int HT  = W + HFP + HSY + HBP;
  localparam int VT  = H + VFP + VSY + VBP;
  localparam int AW  = $clog2(W * H);

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_stb = 1'b0;
  logic swap_req = 1'b0;
  logic swap_ack, front_sel;
  logic [AW-1:0] addr;
  logic [1:0] mem_q = 2'd0;
  logic [3:0] r, g, b;
  logic hs, vs, de, fs;
  bit zero_mode = 1'b0;

  pix_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int mx = 0, my = 0, maddr = 0;
  bit pend = 1'b0, fsel = 1'b0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, since_fs = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_q <= zero_mode ? 2'd0 : addr[1:0];

  fb_scanout #(
    .DRAW_WIDTH(W), .DRAW_HEIGHT(H),
    .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .DRAW_DATAW(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_stb(pix_stb),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .front_sel(front_sel), .draw_addr_read(addr),
    .draw_data_out(mem_q),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .vga_hs(hs), .vga_vs(vs), .vga_de(de),
    .frame_start(fs)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at (%0d,%0d): got=%0d exp=%0d",
                 tag, mx, my, got, exp);
    end
  endtask

  function automatic logic [11:0] pal(input int v);
    case (v)
      0:       return 12'h000;
      1:       return 12'h00F;
      2:       return 12'h0F0;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic pix_t exp_pix(input int x, input int y);
    pix_t p;
    bit bd;
    p.de = (x < W) && (y < H);
    p.hs = !(x >= W + HFP && x < W + HFP + HSY);
    p.vs = !(y >= H + VFP && y < H + VFP + VSY);
    p.rgb = 12'h000;
`ifdef SCANOUT_BORDER_EN
    bd = (x == 0 || x == W - 1 || y == 0 || y == H - 1);
`else
    bd = 1'b0;
`endif
    if (p.de)
      p.rgb = bd ? 12'hFFF : pal(zero_mode ? 0 : (y * W + x) % 4);
    return p;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; maddr = 0;
    fsel = 1'b0; pend = 1'b0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; since_fs = 0;
    sb_q.delete();
  endtask

  task automatic strobe(input bit req);
    pix_t e;
    bit sp, fire, fs_e;
    check_eq("addr", addr, maddr);
    sb_q.push_back(exp_pix(mx, my));
    sp   = (mx == HT - 1) && (my == H - 1);
    fire = sp && (pend || req);
    if (fire) begin
      fsel = ~fsel;
      pend = 1'b0;
    end else if (req) begin
      pend = 1'b1;
    end
    fs_e = (mx == HT - 1) && (my == VT - 1);
    pix_stb = 1'b1;
    swap_req = req;
    @(negedge clk);
    pix_stb = 1'b0;
    swap_req = 1'b0;
    e = sb_q.pop_front();
    check_eq("de", de, e.de);
    check_eq("hs", hs, e.hs);
    check_eq("vs", vs, e.vs);
    check_eq("rgb", {r, g, b}, e.rgb);
    check_eq("swap_ack", swap_ack, fire);
    check_eq("front_sel", front_sel, fsel);
    check_eq("frame_start", fs, fs_e);
    since_fs++;
    if (de) de_cnt++;
    if (!hs) hs_cnt++;
    if (!vs) vs_cnt++;
    if (fs) begin
      check_eq("fs_period", since_fs, HT * VT);
      check_eq("de_count", de_cnt, W * H);
      check_eq("hs_low_count", hs_cnt, HSY * VT);
      check_eq("vs_low_count", vs_cnt, VSY * HT);
      since_fs = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end
    mx++;
    if (mx == HT) begin
      mx = 0;
      my++;
      if (my == VT) my = 0;
    end
    if (mx < W && my < H) maddr = my * W + mx;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check_eq("ack_one_clk", swap_ack, 0);
    check_eq("fs_one_clk", fs, 0);
  endtask

  task automatic goto(input int tx, input int ty);
    int n = 0;
    while (!(mx == tx && my == ty)) begin
      strobe(1'b0);
      n++;
      if (n > HT * VT) begin
        check_eq("goto_bound", n, 0);
        break;
      end
    end
  endtask

  task automatic check_reset();
    check_eq("rst_hs", hs, 1);
    check_eq("rst_vs", vs, 1);
    check_eq("rst_de", de, 0);
    check_eq("rst_rgb", {r, g, b}, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_front_sel", front_sel, 0);
    check_eq("rst_swap_ack", swap_ack, 0);
    check_eq("rst_frame_start", fs, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // two free-running frames
    repeat (2 * HT * VT) strobe(1'b0);

    // mid-frame request waits for the swap point
    goto(4, 3);
    strobe(1'b1);
    goto(HT - 1, H - 1);
    strobe(1'b0);

    // request coincident with the swap point
    goto(HT - 1, H - 1);
    strobe(1'b1);

    // two requests in one frame give one toggle
    goto(2, 1);
    strobe(1'b1);
    goto(7, 5);
    strobe(1'b1);
    goto(HT - 1, H - 1);
    strobe(1'b0);
    goto(HT - 1, H - 1);
    strobe(1'b0);

    // all-zero buffer frame (border visible when enabled)
    goto(0, H);
    zero_mode = 1'b1;
    repeat (HT * VT) strobe(1'b0);
    zero_mode = 1'b0;

    // reset mid-frame drops a pending swap
    goto(0, 2);
    strobe(1'b1);
    goto(3, 5);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    goto(HT - 1, H - 1);
    strobe(1'b0);
    repeat (2 * HT) strobe(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
